// File: rtl/sram_reader_pkg.sv
// rtl/sram_reader_pkg.sv - shared types for the SRAM burst read engine
// Purpose: FSM state encoding used by sram_reader.
// Ports: none (package).
package sram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sram_reader_fifo.sv
// rtl/sram_reader_fifo.sv - 2-entry FIFO holding {last, data} between SRAM and consumer
// Purpose: absorbs consumer back-pressure; push and pop may coincide at any occupancy.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write an entry (caller never pushes when full without a pop)
//   pop             remove the head entry (caller never pops when empty)
//   head            current head entry, zero after reset
//   full, empty     occupancy flags
module sram_reader_fifo #(
  parameter int WIDTH = 257
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       level;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      // When full with a simultaneous pop, wr_ptr equals rd_ptr: the new word
      // lands in the slot being vacated and becomes the tail.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == 2'd2);
  assign empty = (level == 2'd0);

endmodule

// File: rtl/sram_reader.sv
// rtl/sram_reader.sv - burst read engine for the SRAM read port with a valid/ready output stream
// Purpose: accepts {start_address, start_count}, issues one read per cycle on port B,
//          captures q_b and streams the words out with out_last on the final word.
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   start_valid/start_ready/start_address/start_count   burst command handshake
//   enable_b_n, address_b, q_b                 SRAM port B (q_b is combinational)
//   out_valid/out_ready/out_data/out_last      output word stream
//   busy                                       burst in progress (READ or DRAIN)
module sram_reader
  import sram_reader_pkg::*;
#(
  parameter  int WIDTH = 256,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [AW-1:0]    start_address,
  input  logic [CW-1:0]    start_count,
  output logic             enable_b_n,
  output logic [AW-1:0]    address_b,
  input  logic [WIDTH-1:0] q_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   addr_hold_q;
  logic [CW-1:0]   remaining_q;
  logic [AW-1:0]   next_addr;
  logic            last_word;
  logic            issue;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [WIDTH:0]  fifo_head;

  assign start_ready = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign out_valid   = !fifo_empty && !rst;
  assign pop         = out_valid && out_ready;

  // A slot frees up this cycle either because the buffer is not full or
  // because the head is leaving, so issue continues through a pop without a bubble.
  assign issue = !rst && (state_q == READ) && (remaining_q != '0) && (!fifo_full || pop);

  assign last_word  = (remaining_q == CW'(1));
  assign next_addr  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
  assign enable_b_n = !issue;
  // Outside issue cycles the port shows the most recently read address.
  assign address_b  = issue ? addr_q : addr_hold_q;

  assign out_data = fifo_head[WIDTH-1:0];
  assign out_last = fifo_head[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_hold_q <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid && start_ready) begin
            addr_q      <= start_address;
            remaining_q <= start_count;
            if (start_count != '0) begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q      <= next_addr;
            addr_hold_q <= addr_q;
            remaining_q <= remaining_q - CW'(1);
            if (last_word) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Popping while not full means the final entry is leaving.
          if (pop && !fifo_full) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sram_reader_fifo #(
    .WIDTH(WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data ({last_word, q_b}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_sram_reader.sv
// tb/tb_sram_reader.sv - directed and random-ready bench for sram_reader
module tb_sram_reader;

  localparam int WIDTH = 256;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [AW-1:0]    start_address;
  logic [CW-1:0]    start_count;
  logic             enable_b_n;
  logic [AW-1:0]    address_b;
  logic [WIDTH-1:0] q_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  logic [WIDTH-1:0] mem [DEPTH];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign q_b = mem[address_b];

  sram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .start_address (start_address),
    .start_count   (start_count),
    .enable_b_n    (enable_b_n),
    .address_b     (address_b),
    .q_b           (q_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy)
  );

  function automatic logic [WIDTH-1:0] word(input int i);
    logic [31:0] w;
    w = {24'hC0FFEE, 8'(i)};
    return {8{w}};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start_valid = 1'b0; start_address = '0; start_count = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (start_ready !== 1'b0) begin miscompares++; $display("FAIL rst_start_ready got %b want 0", start_ready); end
    vectors++; if (enable_b_n !== 1'b1) begin miscompares++; $display("FAIL rst_enable_b_n got %b want 1", enable_b_n); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_start_ready got %b want 1", start_ready); end
    vectors++; if (address_b !== '0) begin miscompares++; $display("FAIL post_rst_address_b got %0d want 0", address_b); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL post_rst_out_data got %h want 0", out_data); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL post_rst_out_last got %b want 0", out_last); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
  endtask

  // Full-rate burst: handshake at T, reads T+1..T+N, words T+2..T+N+1, idle at T+N+2.
  task automatic burst_full_rate(input int a, input int n, input string tag);
    logic exp_en;
    @(negedge clk);
    start_valid = 1'b1; start_address = AW'(a); start_count = CW'(n); out_ready = 1'b1;
    #1;
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL %s_start_ready got %b want 1", tag, start_ready); end
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      start_valid = 1'b0;
      #1;
      exp_en = (k <= n) ? 1'b0 : 1'b1;
      vectors++; if (enable_b_n !== exp_en) begin miscompares++; $display("FAIL %s_enable k=%0d got %b want %b", tag, k, enable_b_n, exp_en); end
      if (k <= n) begin
        vectors++; if (address_b !== AW'((a + k - 1) % DEPTH)) begin miscompares++; $display("FAIL %s_address k=%0d got %0d want %0d", tag, k, address_b, (a + k - 1) % DEPTH); end
      end
      vectors++; if (out_valid !== (k >= 2)) begin miscompares++; $display("FAIL %s_out_valid k=%0d got %b want %b", tag, k, out_valid, k >= 2); end
      if (k >= 2) begin
        vectors++; if (out_data !== word((a + k - 2) % DEPTH)) begin miscompares++; $display("FAIL %s_out_data k=%0d got %h want %h", tag, k, out_data, word((a + k - 2) % DEPTH)); end
        vectors++; if (out_last !== (k == n + 1)) begin miscompares++; $display("FAIL %s_out_last k=%0d got %b want %b", tag, k, out_last, k == n + 1); end
      end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy k=%0d got %b want 1", tag, k, busy); end
    end
    @(negedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_end got %b want 0", tag, busy); end
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL %s_start_ready_end got %b want 1", tag, start_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_out_valid_end got %b want 0", tag, out_valid); end
  endtask

  task automatic test_basic();
    burst_full_rate(4, 8, "basic");
  endtask

  task automatic test_wrap();
    burst_full_rate(62, 4, "wrap");
  endtask

  task automatic test_single_word();
    burst_full_rate(10, 1, "single");
  endtask

  task automatic test_backpressure();
    int issues;
    int idx;
    issues = 0;
    idx = 0;
    @(negedge clk);
    start_valid = 1'b1; start_address = AW'(0); start_count = CW'(6); out_ready = 1'b1;
    #1;
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL bp_start_ready got %b want 1", start_ready); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start_valid = 1'b0; out_ready = 1'b0;
      #1;
      if (enable_b_n === 1'b0) issues++;
      if (k >= 3) begin
        vectors++; if (out_valid !== 1'b1 || out_data !== word(0) || out_last !== 1'b0) begin
          miscompares++; $display("FAIL bp_stall_hold k=%0d got v=%b d=%h l=%b want v=1 d=%h l=0", k, out_valid, out_data, out_last, word(0));
        end
      end
    end
    vectors++; if (issues != 2) begin miscompares++; $display("FAIL bp_issue_count got %0d want 2", issues); end
    for (int c = 0; c < 20 && idx < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (c == 0) begin
        vectors++; if (enable_b_n !== 1'b0 || address_b !== AW'(2)) begin miscompares++; $display("FAIL bp_resume got en=%b addr=%0d want en=0 addr=2", enable_b_n, address_b); end
      end
      if (out_valid === 1'b1) begin
        vectors++; if (out_data !== word(idx)) begin miscompares++; $display("FAIL bp_data idx=%0d got %h want %h", idx, out_data, word(idx)); end
        vectors++; if (out_last !== (idx == 5)) begin miscompares++; $display("FAIL bp_last idx=%0d got %b want %b", idx, out_last, idx == 5); end
        idx++;
      end
    end
    vectors++; if (idx != 6) begin miscompares++; $display("FAIL bp_word_count got %0d want 6", idx); end
    @(negedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy_end got %b want 0", busy); end
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    start_valid = 1'b1; start_address = AW'(5); start_count = CW'(0); out_ready = 1'b1;
    #1;
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL zero_start_ready got %b want 1", start_ready); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start_valid = 1'b0;
      #1;
      vectors++; if (enable_b_n !== 1'b1 || out_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++; $display("FAIL zero_idle k=%0d got en=%b v=%b sr=%b busy=%b want 1 0 1 0", k, enable_b_n, out_valid, start_ready, busy);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int popped;
    popped = 0;
    @(negedge clk);
    start_valid = 1'b1; start_address = AW'(8); start_count = CW'(8); out_ready = 1'b1;
    for (int c = 0; c < 20 && popped < 3; c++) begin
      @(negedge clk);
      start_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        vectors++; if (out_data !== word(8 + popped) || out_last !== 1'b0) begin miscompares++; $display("FAIL midrst_data idx=%0d got %h l=%b want %h l=0", popped, out_data, out_last, word(8 + popped)); end
        popped++;
      end
    end
    vectors++; if (popped != 3) begin miscompares++; $display("FAIL midrst_popped got %0d want 3", popped); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || enable_b_n !== 1'b1 || busy !== 1'b0 || start_ready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_state got v=%b en=%b busy=%b sr=%b want 0 1 0 1", out_valid, enable_b_n, busy, start_ready);
    end
    burst_full_rate(0, 2, "post_rst");
  endtask

  task automatic test_random_ready();
    int a, n, idx;
    bit done, have_prev, prev_last;
    logic [WIDTH-1:0] prev_data;
    for (int b = 0; b < 100; b++) begin
      a = $urandom_range(0, DEPTH - 1);
      n = (b % 25 == 7) ? DEPTH : $urandom_range(0, 12);
      @(negedge clk);
      start_valid = 1'b1; start_address = AW'(a); start_count = CW'(n); out_ready = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL rnd_start_ready b=%0d got %b want 1", b, start_ready); end
      idx = 0; done = 1'b0; have_prev = 1'b0; prev_last = 1'b0; prev_data = '0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        start_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
        #1;
        if (busy === 1'b1) begin
          vectors++; if (start_ready !== 1'b0) begin miscompares++; $display("FAIL rnd_ready_while_busy b=%0d got %b want 0", b, start_ready); end
        end
        if (have_prev) begin
          vectors++; if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            miscompares++; $display("FAIL rnd_stall_stable b=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", b, out_valid, out_data, out_last, prev_data, prev_last);
          end
        end
        have_prev = (out_valid === 1'b1) && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
        if (out_valid === 1'b1 && out_ready) begin
          vectors++; if (out_data !== word((a + idx) % DEPTH)) begin miscompares++; $display("FAIL rnd_data b=%0d idx=%0d got %h want %h", b, idx, out_data, word((a + idx) % DEPTH)); end
          vectors++; if (out_last !== (idx == n - 1)) begin miscompares++; $display("FAIL rnd_last b=%0d idx=%0d got %b want %b", b, idx, out_last, idx == n - 1); end
          idx++;
        end
        if (idx == n && busy === 1'b0) done = 1'b1;
      end
      vectors++; if (!done || idx != n) begin miscompares++; $display("FAIL rnd_complete b=%0d got %0d words want %0d", b, idx, n); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = word(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_single_word();
    test_reset_mid_burst();
    test_random_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_reader.md
# sram_reader

Streaming read engine for the dual-port `sram` macro's read port (port B). It accepts a burst command (start address and word count) and issues one active-low read per cycle on port B. It captures `q_b` and delivers the words on a valid/ready output stream, with `out_last` marking the final word. It sits between the SRAM and any downstream consumer (DMA, serializer, compute lane) and absorbs consumer back-pressure with a 2-entry buffer.

## Interface
Parameters:
- `WIDTH`, 256, word width; must match the attached `sram`.
- `DEPTH`, 64, number of SRAM words; any value ≥ 2; `AW = $clog2(DEPTH)`, `CW = $clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  burst command valid.
- `start_ready`  out  1  command accepted when both high; high only in IDLE and not in reset.
- `start_address`  in  AW  first word address; values ≥ DEPTH are illegal.
- `start_count`  in  CW  words to read, 0..DEPTH.
- `enable_b_n`  out  1  to `sram.enable_b_n`; low only on read-issue cycles.
- `address_b`  out  AW  to `sram.address_b`.
- `q_b`  in  WIDTH  from `sram.q_b`; combinational read, sampled in the issue cycle.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  WIDTH  output word.
- `out_last`  out  1  qualifies the final word of the burst.
- `busy`  out  1  high in READ or DRAIN.

## Operation
- FSM states:
  - IDLE → READ on a command handshake with count > 0.
  - Count = 0: command accepted, no read, no output, FSM stays IDLE.
  - READ → DRAIN on the cycle the last read issues.
  - DRAIN → IDLE on the cycle the last word pops.
- Command handshake latches `start_address` into `addr_q` and `start_count` into `remaining_q`.
- Issue rule in READ: read issues when `remaining_q > 0` and the buffer will have a free slot this cycle, i.e. occupancy < 2, or occupancy == 2 with a pop this cycle.
- On issue:
  - `enable_b_n` = 0 and `address_b` = `addr_q`.
  - `q_b` is pushed with last flag = (`remaining_q` == 1).
  - `remaining_q` decrements.
  - `addr_q` advances, wrapping from DEPTH-1 to 0; this wrap works for non-power-of-two DEPTH.
- Buffer: 2-entry FIFO; head drives `out_data`/`out_last`; `out_valid` = not empty; pop on `out_valid && out_ready`; push and pop in the same cycle are legal at any occupancy.
- Output words appear in address order, with no duplicates and no drops.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.
- `address_b` holds its last value when idle; `enable_b_n` = 1 whenever no read issues.
- Reset values: `enable_b_n`=1, `address_b`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `start_ready`=0 during reset and 1 from the first cycle after.
- Reset mid-burst: FIFO flushed, burst abandoned, no `out_last` emitted, FSM returns to IDLE.

## Timing
- Handshake in cycle T → first read issues in T+1 → `out_valid` high in T+2.
- With `out_ready` held high: one word per cycle; N words issue in T+1..T+N, pop in T+2..T+N+1.
- `busy` is high T+1..T+N+1.
- `start_ready` reasserts in T+N+2, so the back-to-back command gap is 1 cycle.
- Back-pressure: with `out_ready` low, at most 2 reads issue before stalling. Issue resumes in the same cycle `out_ready` rises, so no bubble after a stall.
- Single-word burst (N=1): read at T+1, `out_valid`+`out_last` at T+2.

## Structure
- Package `sram_reader_pkg`: `state_e` enum (IDLE, READ, DRAIN).
- Sub-module `sram_reader_fifo`: 2-entry, WIDTH+1 bits (data + last), push/pop/full/empty, synchronous active-high reset.
- Top holds the FSM, address/count registers and issue logic.

## Test plan
- DEPTH=64; preload memory[i]=i; command addr=4, count=8, `out_ready`=1 → words 4..11 on consecutive cycles T+2..T+9; `out_last` only on 11; `busy` low at T+10.
- Wrap: addr=62, count=4 → output 62, 63, 0, 1; `address_b` sequence identical.
- Back-pressure: count=6, `out_ready` low T+2..T+7 → exactly 2 reads issue, then `enable_b_n` stays 1. After release, 0..5 arrive in order with no loss or duplication.
- Count=0 → accepted, `enable_b_n` never low, `out_valid` never high, `start_ready` stays 1. Count=1 → single word with `out_last`.
- Reset asserted mid-burst (after 3 of 8 words) → next cycle `out_valid`=0, `enable_b_n`=1, `busy`=0. A new burst addr=0, count=2 then yields 0, 1 correctly.
- Random `out_ready` (50 %), 100 random bursts → scoreboard matches, `out_data` stable under stall, `start_ready` low whenever `busy`.
